// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle around mem_port_arbiter: CPU fetch port, CPU data port and the memory-side port.
// Signal prefixes (i_/o_) are named from the arbiter's point of view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_ifReq;
    logic [ADDR_W-1:0] i_ifAddr;
    logic              o_ifGnt;
    logic              o_ifRvalid;
    logic [DATA_W-1:0] o_ifRdata;

    logic              i_dReq;
    logic              i_dWe;
    logic [3:0]        i_dBe;
    logic [ADDR_W-1:0] i_dAddr;
    logic [DATA_W-1:0] i_dWdata;
    logic              o_dGnt;
    logic              o_dRvalid;
    logic [DATA_W-1:0] o_dRdata;

    logic              o_memReq;
    logic              o_memWe;
    logic [3:0]        o_memBe;
    logic [ADDR_W-1:0] o_memAddr;
    logic [DATA_W-1:0] o_memWdata;
    logic              i_memReady;
    logic              i_memRvalid;
    logic [DATA_W-1:0] i_memRdata;

    logic              o_busy;
    logic              o_errResp;

    modport slave (
        input  i_ifReq, i_ifAddr, i_dReq, i_dWe, i_dBe, i_dAddr, i_dWdata,
        input  i_memReady, i_memRvalid, i_memRdata,
        output o_ifGnt, o_ifRvalid, o_ifRdata, o_dGnt, o_dRvalid, o_dRdata,
        output o_memReq, o_memWe, o_memBe, o_memAddr, o_memWdata, o_busy, o_errResp
    );

    modport master (
        output i_ifReq, i_ifAddr, i_dReq, i_dWe, i_dBe, i_dAddr, i_dWdata,
        output i_memReady, i_memRvalid, i_memRdata,
        input  o_ifGnt, o_ifRvalid, o_ifRdata, o_dGnt, o_dRvalid, o_dRdata,
        input  o_memReq, o_memWe, o_memBe, o_memAddr, o_memWdata, o_busy, o_errResp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store traffic.
// Data has priority; a starvation counter forces a fetch win after STARVE_LIMIT data wins.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_clock,
    input  logic                i_resetn,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    logic              r_owner_d;
    logic [3:0]        r_starve;
    logic              r_we;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_if_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err;

    logic              w_any_req;
    logic              w_data_wins;
    logic              w_in_req;

    assign w_any_req   = bus.i_ifReq | bus.i_dReq;
    // Data wins whenever it asks, except when a waiting fetch has already lost STARVE_LIMIT times in a row.
    assign w_data_wins = bus.i_dReq & ~(bus.i_ifReq & (r_starve == C_LIMIT));
    assign w_in_req    = (r_state == S_REQ);

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_starve    <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= '0;
            if (bus.i_memRvalid && (r_state != S_RESP)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= S_REQ;
                        r_owner_d <= w_data_wins;
                        if (w_data_wins) begin
                            r_we    <= bus.i_dWe;
                            r_be    <= bus.i_dBe;
                            r_addr  <= bus.i_dAddr;
                            r_wdata <= bus.i_dWdata;
                            if (bus.i_ifReq && (r_starve != C_LIMIT)) begin
                                r_starve <= r_starve + 4'd1;
                            end else if (!bus.i_ifReq) begin
                                r_starve <= '0;
                            end
                        end else begin
                            r_we     <= 1'b0;
                            r_be     <= 4'hF;
                            r_addr   <= bus.i_ifAddr;
                            r_wdata  <= '0;
                            r_starve <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.i_memReady) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.i_memRvalid) begin
                        r_state <= S_IDLE;
                        if (r_owner_d) begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= r_we ? '0 : bus.i_memRdata;
                        end else begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= bus.i_memRdata;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Grants are combinational so the requester learns of acceptance in the same cycle as the memory.
    assign bus.o_ifGnt    = w_in_req & bus.i_memReady & ~r_owner_d;
    assign bus.o_dGnt     = w_in_req & bus.i_memReady &  r_owner_d;
    assign bus.o_ifRvalid = r_if_rvalid;
    assign bus.o_ifRdata  = r_if_rdata;
    assign bus.o_dRvalid  = r_d_rvalid;
    assign bus.o_dRdata   = r_d_rdata;
    assign bus.o_memReq   = w_in_req;
    assign bus.o_memWe    = r_we;
    assign bus.o_memBe    = r_be;
    assign bus.o_memAddr  = r_addr;
    assign bus.o_memWdata = r_wdata;
    assign bus.o_busy     = (r_state != S_IDLE);
    assign bus.o_errResp  = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers push expectations, a negedge monitor pops and compares.
module tb_mem_port_arbiter;
    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } op_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .i_clock  (clk),
        .i_resetn (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    op_t         exp_if_req[$];
    op_t         exp_d_req[$];
    logic [31:0] exp_if_resp[$];
    logic [31:0] exp_d_resp[$];
    bit          grant_log[$];
    int          gnt_cyc_q[$];
    logic [31:0] shadow [logic [31:0]];
    logic [31:0] mem_store [logic [31:0]];

    int  if_gnt_cyc, d_gnt_cyc, if_rv_cyc, d_rv_cyc, req_hi_cnt, d_gnt_cnt;
    bit  err_expected = 1'b0;
    int  rdy_wait = 0;
    int  rv_wait = 0;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return init_word(a);
    endfunction

    // Memory model: ready after rdy_wait stalled cycles, response rv_wait cycles after acceptance.
    initial begin
        bit          accept_pending;
        bit          resp_pending;
        int          resp_cnt;
        int          req_cnt;
        logic [31:0] resp_data;
        logic        a_we;
        logic [3:0]  a_be;
        logic [31:0] a_addr, a_wdata;
        accept_pending = 0; resp_pending = 0; resp_cnt = 0; req_cnt = 0; resp_data = '0;
        a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
        bus.i_memReady = 1'b0; bus.i_memRvalid = 1'b0; bus.i_memRdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.i_memRvalid = 1'b0;
            bus.i_memRdata  = $urandom;
            if (accept_pending) begin
                accept_pending = 0;
                if (a_we) begin
                    mem_store[a_addr] = merge_be(mem_rd(a_addr), a_wdata, a_be);
                    resp_data = $urandom | 32'h1;
                end else begin
                    resp_data = mem_rd(a_addr);
                end
                resp_pending = 1;
                resp_cnt = rv_wait;
            end
            if (resp_pending) begin
                if (resp_cnt == 0) begin
                    bus.i_memRvalid = 1'b1;
                    bus.i_memRdata  = resp_data;
                    resp_pending = 0;
                end else begin
                    resp_cnt--;
                end
            end
            bus.i_memReady = 1'b0;
            if (bus.o_memReq) begin
                if (req_cnt >= rdy_wait) begin
                    bus.i_memReady = 1'b1;
                    accept_pending = 1;
                    req_cnt = 0;
                    a_we = bus.o_memWe; a_be = bus.o_memBe;
                    a_addr = bus.o_memAddr; a_wdata = bus.o_memWdata;
                end else begin
                    req_cnt++;
                end
            end
        end
    end

    task automatic cmp_req(input string who, input op_t e);
        check_value({who, "_mem_addr"}, bus.o_memAddr, e.addr);
        check_value({who, "_mem_we_be"}, {bus.o_memWe, bus.o_memBe}, {e.we, e.be});
        check_value({who, "_mem_wdata"}, bus.o_memWdata, e.wdata);
    endtask

    // Monitor: samples on the falling edge, well away from the rising edge where state moves.
    initial begin
        op_t         op;
        logic        prev_req, prev_gnt;
        logic [31:0] prev_addr;
        logic [36:0] prev_ctl;
        prev_req = 0; prev_gnt = 0; prev_addr = '0; prev_ctl = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.o_memReq) req_hi_cnt++;
                if (bus.o_memReq && prev_req && !prev_gnt) begin
                    check_value("req_addr_stable", bus.o_memAddr, prev_addr);
                    check_value("req_ctl_stable", {bus.o_memWe, bus.o_memBe, bus.o_memWdata}, prev_ctl);
                end
                if (bus.o_ifGnt || bus.o_dGnt) begin
                    check_value("gnt_onehot", {bus.o_ifGnt, bus.o_dGnt} == 2'b11, 0);
                    check_value("gnt_with_memreq", bus.o_memReq, 1);
                end
                if (bus.o_ifGnt) begin
                    check_value("if_gnt_expected", exp_if_req.size() != 0, 1);
                    if (exp_if_req.size() != 0) begin
                        op = exp_if_req.pop_front();
                        cmp_req("if", op);
                        exp_if_resp.push_back(op.rdata);
                    end
                    if_gnt_cyc = cyc; grant_log.push_back(1'b0); gnt_cyc_q.push_back(cyc);
                end
                if (bus.o_dGnt) begin
                    check_value("d_gnt_expected", exp_d_req.size() != 0, 1);
                    if (exp_d_req.size() != 0) begin
                        op = exp_d_req.pop_front();
                        cmp_req("d", op);
                        exp_d_resp.push_back(op.rdata);
                    end
                    d_gnt_cyc = cyc; d_gnt_cnt++; grant_log.push_back(1'b1); gnt_cyc_q.push_back(cyc);
                end
                if (bus.o_ifRvalid) begin
                    check_value("if_rvalid_expected", exp_if_resp.size() != 0, 1);
                    if (exp_if_resp.size() != 0) check_value("if_rdata", bus.o_ifRdata, exp_if_resp.pop_front());
                    if_rv_cyc = cyc;
                end else begin
                    check_value("if_rdata_idle", bus.o_ifRdata, 0);
                end
                if (bus.o_dRvalid) begin
                    check_value("d_rvalid_expected", exp_d_resp.size() != 0, 1);
                    if (exp_d_resp.size() != 0) check_value("d_rdata", bus.o_dRdata, exp_d_resp.pop_front());
                    d_rv_cyc = cyc;
                end else begin
                    check_value("d_rdata_idle", bus.o_dRdata, 0);
                end
                if (!err_expected) check_value("err_clear", bus.o_errResp, 0);
                prev_req  = bus.o_memReq;
                prev_gnt  = bus.o_ifGnt | bus.o_dGnt;
                prev_addr = bus.o_memAddr;
                prev_ctl  = {bus.o_memWe, bus.o_memBe, bus.o_memWdata};
            end else begin
                prev_req = 0; prev_gnt = 0;
            end
        end
    end

    task automatic wait_gnt(input bit is_data, input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (is_data ? bus.o_dGnt : bus.o_ifGnt) begin ok = 1; break; end
        end
        check_value({tag, "_gnt_timeout"}, ok, 1);
    endtask

    task automatic drive_fetch(input logic [31:0] a);
        op_t e;
        e.we = 0; e.be = 4'hF; e.addr = a; e.wdata = '0; e.rdata = shadow_rd(a);
        exp_if_req.push_back(e);
        bus.i_ifReq = 1'b1; bus.i_ifAddr = a;
    endtask

    // Called and returns at posedge+1; request held until its grant.
    task automatic issue_fetch(input logic [31:0] a);
        drive_fetch(a);
        wait_gnt(0, "fetch");
        @(posedge clk); #1;
        bus.i_ifReq = 1'b0;
    endtask

    task automatic issue_data(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        op_t e;
        e.we = we; e.be = be; e.addr = a; e.wdata = wd;
        e.rdata = we ? 32'h0 : shadow_rd(a);
        if (we) shadow[a] = merge_be(shadow_rd(a), wd, be);
        exp_d_req.push_back(e);
        bus.i_dReq = 1'b1; bus.i_dWe = we; bus.i_dBe = be; bus.i_dAddr = a; bus.i_dWdata = wd;
        wait_gnt(1, "data");
        @(posedge clk); #1;
        bus.i_dReq = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (exp_if_req.size() == 0 && exp_d_req.size() == 0 && exp_if_resp.size() == 0 &&
                exp_d_resp.size() == 0 && !bus.o_busy) begin
                ok = 1; break;
            end
        end
        check_value({tag, "_drain_timeout"}, ok, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_ctrl"}, {bus.o_ifGnt, bus.o_ifRvalid, bus.o_dGnt, bus.o_dRvalid, bus.o_memReq,
                                     bus.o_memWe, bus.o_memBe, bus.o_busy, bus.o_errResp}, 0);
        check_value({tag, "_rdata"}, {bus.o_ifRdata, bus.o_dRdata}, 0);
        check_value({tag, "_mem_bus"}, {bus.o_memAddr, bus.o_memWdata}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          t0;
        bit          exp_order[10];
        logic [31:0] a;
        clk = 0; rst_n = 0;
        bus.i_ifReq = 0; bus.i_ifAddr = '0;
        bus.i_dReq = 0; bus.i_dWe = 0; bus.i_dBe = '0; bus.i_dAddr = '0; bus.i_dWdata = '0;
        req_hi_cnt = 0; d_gnt_cnt = 0; if_gnt_cyc = 0; d_gnt_cyc = 0; if_rv_cyc = 0; d_rv_cyc = 0;
        shadow[32'h10] = 32'h0010_0093;
        mem_store[32'h10] = 32'h0010_0093;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;

        // Single fetch with immediate ready/rvalid
        req_hi_cnt = 0; t0 = cyc;
        issue_fetch(32'h0000_0010);
        wait_drain("fetch1");
        check_value("fetch_gnt_latency", if_gnt_cyc - t0, 1);
        check_value("fetch_rvalid_latency", if_rv_cyc - t0, 3);
        check_value("fetch_memreq_cycles", req_hi_cnt, 1);
        $display("txn fetch addr=00000010 gnt@%0d rvalid@%0d", if_gnt_cyc - t0, if_rv_cyc - t0);

        // Store with two stall cycles, then read it back
        rdy_wait = 2; req_hi_cnt = 0; d_gnt_cnt = 0;
        issue_data(1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
        wait_drain("store");
        check_value("store_memreq_cycles", req_hi_cnt, 3);
        check_value("store_gnt_count", d_gnt_cnt, 1);
        $display("txn store addr=00000100 be=3 memreq_cycles=%0d", req_hi_cnt);
        rdy_wait = 0;
        issue_data(1'b0, 4'hF, 32'h100, 32'h0);
        wait_drain("load_back");
        $display("txn load addr=00000100 expect=%08h", shadow_rd(32'h100));

        // Contention: both held, starvation guard decides the order
        grant_log.delete(); gnt_cyc_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = 32'h200 + 32'(4 * (i / 2));
                    if (i % 2 == 0) issue_data(1'b1, 4'($urandom_range(1, 15)), a, $urandom);
                    else            issue_data(1'b0, 4'hF, a, 32'h0);
                end
            end
            begin
                issue_fetch(32'h1000);
                issue_fetch(32'h1004);
            end
        join
        wait_drain("contention");
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        check_value("contention_grants", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
            check_value($sformatf("grant_order_%0d", i), grant_log[i], exp_order[i]);
            $display("txn contention grant %0d -> %s", i, grant_log[i] ? "D" : "F");
        end
        if (gnt_cyc_q.size() >= 2) check_value("b2b_spacing", gnt_cyc_q[1] - gnt_cyc_q[0], 3);

        // Response back-pressure with a fetch waiting behind it
        rv_wait = 5;
        issue_data(1'b0, 4'hF, 32'h200, 32'h0);
        drive_fetch(32'h1008);
        ok = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.o_dRvalid) begin ok = 1; break; end
            check_value("bp_busy", bus.o_busy, 1);
            check_value("bp_no_memreq", bus.o_memReq, 0);
        end
        check_value("bp_resp_seen", ok, 1);
        check_value("bp_pulse_idle", {bus.o_busy, bus.o_memReq}, 0);
        wait_gnt(0, "bp_fetch");
        @(posedge clk); #1;
        bus.i_ifReq = 1'b0;
        check_value("bp_fetch_after_resp", if_gnt_cyc - d_rv_cyc, 1);
        wait_drain("backpressure");
        $display("txn backpressure load rvalid@%0d fetch gnt@%0d", d_rv_cyc, if_gnt_cyc);

        // Reset during RESP, then a stray response
        issue_data(1'b0, 4'hF, 32'h204, 32'h0);
        @(negedge clk); #2;
        rst_n = 0; #1;
        check_all_zero("midresp_reset");
        exp_d_resp.delete();
        err_expected = 1'b1;
        @(posedge clk); #3 rst_n = 1;
        repeat (10) @(posedge clk);
        #1;
        check_value("stray_rvalid_err", bus.o_errResp, 1);
        check_value("stray_not_busy", bus.o_busy, 0);
        $display("txn reset mid-RESP, errResp=%0b", bus.o_errResp);

        // Reset clears the sticky error and the arbiter works again
        rst_n = 0; #1;
        check_all_zero("err_reset");
        err_expected = 1'b0;
        rv_wait = 0;
        @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;
        issue_fetch(32'h1000);
        wait_drain("recover");
        $display("txn recovery fetch addr=00001000");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the CPU instruction-fetch path and the load/store data path.
- Fixed priority to data with a fetch starvation guard; at most one outstanding memory transaction.
- Sits between the CPU core (program-counter fetch port, data port) and the unified memory model/wrapper.
- Request/accept handshake on the memory side; separate response valid per requester.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports; must be 32 (byte enables are 4 bits).
- STARVE_LIMIT, 4, consecutive data wins over a pending fetch before fetch is forced to win; range 1..15.

Ports:
- i_clock  in  1  clock, rising edge.
- i_resetn  in  1  asynchronous active-low reset.
- i_ifReq  in  1  fetch request; held with i_ifAddr until o_ifGnt.
- i_ifAddr  in  ADDR_W  fetch address.
- o_ifGnt  out  1  fetch request accepted by memory this cycle.
- o_ifRvalid  out  1  fetch read data valid, 1-cycle pulse.
- o_ifRdata  out  DATA_W  fetch read data.
- i_dReq  in  1  data request; held with all i_d* until o_dGnt.
- i_dWe  in  1  1 = store, 0 = load.
- i_dBe  in  4  store byte enables.
- i_dAddr  in  ADDR_W  data address.
- i_dWdata  in  DATA_W  store data.
- o_dGnt  out  1  data request accepted by memory this cycle.
- o_dRvalid  out  1  data response (load data or store ack), 1-cycle pulse.
- o_dRdata  out  DATA_W  load data; 0 for store responses.
- o_memReq  out  1  memory request valid.
- o_memWe  out  1  memory write enable.
- o_memBe  out  4  memory byte enables.
- o_memAddr  out  ADDR_W  memory address.
- o_memWdata  out  DATA_W  memory write data.
- i_memReady  in  1  memory accepts request when high with o_memReq.
- i_memRvalid  in  1  memory response valid (reads and writes), one per accepted request.
- i_memRdata  in  DATA_W  memory read data.
- o_busy  out  1  state != IDLE.
- o_errResp  out  1  sticky: i_memRvalid seen outside RESP.

Behaviour:
- Reset (async, i_resetn=0): state IDLE, owner=fetch, starve counter 0; every output 0. Reset mid-transaction abandons it; later stray i_memRvalid sets o_errResp.
- FSM IDLE -> REQ -> RESP -> IDLE.
- IDLE: if any request, arbitrate, register owner and fields (fetch: We=0, Be=4'hF, Wdata=0) and go REQ. Otherwise stay.
- Arbitration when both pending: data wins unless counter == STARVE_LIMIT, then fetch wins. Single requester always wins.
- Counter: +1 when data wins while i_ifReq=1; clears when fetch wins or when i_ifReq=0 at arbitration; saturates at STARVE_LIMIT.
- REQ: o_memReq=1 with registered fields, stable until accepted. On i_memReady=1: owner's o_*Gnt=1 (combinational, that cycle only), go RESP.
- RESP: o_memReq=0. On i_memRvalid=1: next cycle owner's o_*Rvalid=1 with registered i_memRdata (o_dRdata=0 for stores); state IDLE that same cycle.
- Rvalid/rdata are 0 when not pulsing. Non-owner gnt/rvalid never assert.
- The IDLE cycle coinciding with the Rvalid pulse arbitrates new requests. Minimum transaction is 3 cycles: IDLE, REQ, RESP. Back-to-back throughput is 1 transaction per 3 cycles with ready/rvalid immediate.
- Requests arriving in REQ/RESP wait; requester must hold. Dropping a request before gnt is illegal and unspecified once sampled.
- i_memRvalid in IDLE or REQ: ignored, o_errResp set until reset.
- Addresses are passed unmodified; alignment is not checked.

Test Plan:
- Reset: i_resetn=0 mid-RESP -> all outputs 0 asynchronously, state IDLE; later i_memRvalid -> o_errResp=1.
- Single fetch: i_ifReq=1, addr 0x0000_0010, ready=1, rvalid next cycle with data 0x0010_0093 -> o_memReq=1 (We=0, Be=F) one cycle, o_ifGnt same cycle, o_ifRvalid=1 with 0x0010_0093 three cycles after request.
- Store: i_dReq=1, We=1, Be=4'b0011, addr 0x100, wdata 0xDEADBEEF; ready held 0 for 2 cycles -> memory fields stable, o_dGnt only on ready cycle, o_dRvalid=1 with o_dRdata=0.
- Contention: both requests held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- Back-pressure on response: rvalid delayed 5 cycles -> o_busy=1 throughout, no new o_memReq until after the response pulse.
